// File: rtl/msb_force_pipe_pkg.sv
// rtl/msb_force_pipe_pkg.sv - shared mode encodings and field-clamp helper for msb_force_pipe
package msb_force_pipe_pkg;

  // Upper-bit rewrite modes carried on in_mode
  typedef enum logic [1:0] {
    MSBF_PASS = 2'b00,
    MSBF_ZERO = 2'b01,
    MSBF_SIGN = 2'b10,
    MSBF_ONES = 2'b11
  } msbf_mode_e;

  // Requested field widths beyond the datapath mean "keep everything"
  function automatic int unsigned msbf_clamp_field(input int unsigned field,
                                                   input int unsigned limit);
    return (field > limit) ? limit : field;
  endfunction

endpackage

// File: rtl/msbf_skid_buf.sv
// rtl/msbf_skid_buf.sv - 2-entry valid/ready skid buffer (output register plus one skid register)
module msbf_skid_buf #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         out_free;

  // in_ready comes straight from a flop so upstream sees no combinational path from out_ready
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  // Output register can take a new word when it is empty or being drained this cycle
  assign out_free = !out_valid || out_ready;

  // Output register fed from skid first (oldest beat), else from the input; stalled beats park in skid
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        // skid full implies in_ready was low, so no input beat competes here
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/msb_force_pipe.sv
// rtl/msb_force_pipe.sv - registered MSB-forcing unit; MSBF_LOST_CNT_EN adds a saturating lost-beat counter
module msb_force_pipe
  import msb_force_pipe_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int CNT_W  = 8,
  localparam int FW_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  input  logic [FW_W-1:0]   in_field,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_lost
`ifdef MSBF_LOST_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  lost_cnt
`endif
);

  logic [FW_W-1:0]   field_c;
  logic [DATA_W-1:0] keep_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] forced_data;
  logic              forced_lost;
  logic [DATA_W:0]   buf_out;

  // Clamp the field, build the keep mask and pick the sign bit in[f-1] without a variable index
  always_comb begin
    field_c   = FW_W'(msbf_clamp_field(32'(in_field), $unsigned(DATA_W)));
    keep_mask = '0;
    sign_bit  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      keep_mask[i] = (FW_W'(i) < field_c);
      if (FW_W'(i + 1) == field_c) begin
        sign_bit = in_data[i];
      end
    end
  end

  // Rewrite the upper bits by mode; SIGN with f=0 has no sign bit and degenerates to ZERO
  always_comb begin
    forced_data = in_data;
    case (msbf_mode_e'(in_mode))
      MSBF_PASS: forced_data = in_data;
      MSBF_ZERO: forced_data = in_data & keep_mask;
      MSBF_SIGN: forced_data = (in_data & keep_mask) | ({DATA_W{sign_bit}} & ~keep_mask);
      MSBF_ONES: forced_data = in_data | ~keep_mask;
      default:   forced_data = in_data;
    endcase
    forced_lost = (forced_data != in_data);
  end

  msbf_skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({forced_lost, forced_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_data = buf_out[DATA_W-1:0];
  assign out_lost = buf_out[DATA_W];

`ifdef MSBF_LOST_CNT_EN
  // Count lost beats as they leave; clear wins over increment, saturate at all-ones
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      lost_cnt <= '0;
    end else if (out_valid && out_ready && out_lost && (lost_cnt != '1)) begin
      lost_cnt <= lost_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_msb_force_pipe.sv
// tb/tb_msb_force_pipe.sv - directed table-driven bench for msb_force_pipe (counter checks under MSBF_LOST_CNT_EN)
module tb_msb_force_pipe;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int FW_W   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic [FW_W-1:0]   in_field;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_lost;
`ifdef MSBF_LOST_CNT_EN
  logic              cnt_clr;
  logic [CNT_W-1:0]  lost_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msb_force_pipe #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_field  (in_field),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lost  (out_lost)
`ifdef MSBF_LOST_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .lost_cnt  (lost_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  field;
    logic [15:0] data;
    logic [15:0] exp_data;
    logic        exp_lost;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [4:0] f, input logic [15:0] d);
    in_valid = v;
    in_mode  = m;
    in_field = f;
    in_data  = d;
  endtask

  initial begin
    vecs[0]  = '{2'b01, 5'd12, 16'hF123, 16'h0123, 1'b1};
    vecs[1]  = '{2'b10, 5'd12, 16'h0923, 16'hF923, 1'b1};
    vecs[2]  = '{2'b10, 5'd12, 16'h0123, 16'h0123, 1'b0};
    vecs[3]  = '{2'b11, 5'd8,  16'h1234, 16'hFF34, 1'b1};
    vecs[4]  = '{2'b01, 5'd0,  16'hABCD, 16'h0000, 1'b1};
    vecs[5]  = '{2'b01, 5'd20, 16'hABCD, 16'hABCD, 1'b0};
    vecs[6]  = '{2'b00, 5'd0,  16'hABCD, 16'hABCD, 1'b0};
    vecs[7]  = '{2'b10, 5'd0,  16'hABCD, 16'h0000, 1'b1};
    vecs[8]  = '{2'b11, 5'd16, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{2'b11, 5'd0,  16'h1234, 16'hFFFF, 1'b1};
    vecs[10] = '{2'b10, 5'd1,  16'h0001, 16'hFFFF, 1'b1};
    vecs[11] = '{2'b10, 5'd15, 16'h8000, 16'h0000, 1'b1};
    vecs[12] = '{2'b01, 5'd31, 16'h1234, 16'h1234, 1'b0};
    vecs[13] = '{2'b10, 5'd16, 16'h8123, 16'h8123, 1'b0};
    vecs[14] = '{2'b11, 5'd4,  16'hFFF0, 16'hFFF0, 1'b0};

    reset     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 5'd16, 16'h0000);
`ifdef MSBF_LOST_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_lost", 32'(out_lost), 32'd0);
`ifdef MSBF_LOST_CNT_EN
    check("reset lost_cnt", 32'(lost_cnt), 32'd0);
`endif

    // Single beats at full throughput with hand-computed results
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].mode, vecs[i].field, vecs[i].data);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d out_lost", i), 32'(out_lost), 32'(vecs[i].exp_lost));
    end
    @(negedge clk);
    check("drain out_valid", 32'(out_valid), 32'd0);

    // Stall: three beats offered, two stored, third waits for space
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 5'd16, 16'h0001);
    check("stall beat1 in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd16, 16'h0002);
    check("stall beat2 in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd16, 16'h0003);
    check("stall full in_ready", 32'(in_ready), 32'd0);
    check("stall head data", 32'(out_data), 32'h0001);
    repeat (2) @(negedge clk);
    check("stall hold in_ready", 32'(in_ready), 32'd0);
    check("stall hold valid", 32'(out_valid), 32'd1);
    check("stall hold data", 32'(out_data), 32'h0001);
    out_ready = 1'b1;
    @(negedge clk);
    check("release out2 data", 32'(out_data), 32'h0002);
    check("release out2 valid", 32'(out_valid), 32'd1);
    check("release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("release out3 data", 32'(out_data), 32'h0003);
    check("release out3 valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("release drained", 32'(out_valid), 32'd0);

    // Reset with both registers full drops everything, including the beat offered during reset
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 5'd16, 16'h0011);
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd16, 16'h0022);
    @(negedge clk);
    check("full before reset in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 2'b00, 5'd16, 16'h0033);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    check("mid reset out_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 5'd8, 16'hA544);
    @(negedge clk);
    in_valid = 1'b0;
    check("post reset valid", 32'(out_valid), 32'd1);
    check("post reset data", 32'(out_data), 32'h0044);
    check("post reset lost", 32'(out_lost), 32'd1);
    @(negedge clk);
    check("post reset drained", 32'(out_valid), 32'd0);

`ifdef MSBF_LOST_CNT_EN
    // The one lost beat above was counted
    check("cnt after one", 32'(lost_cnt), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("cnt reset", 32'(lost_cnt), 32'd0);
    drive(1'b1, 2'b01, 5'd0, 16'hFFFF);
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("cnt saturate", 32'(lost_cnt), 32'd255);
    drive(1'b1, 2'b01, 5'd0, 16'hFFFF);
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    check("clr beat lost", 32'(out_lost), 32'd1);
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr wins", 32'(lost_cnt), 32'd0);
    drive(1'b1, 2'b00, 5'd0, 16'hFFFF);
    @(negedge clk);
    drive(1'b1, 2'b11, 5'd0, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("cnt pass not counted", 32'(lost_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
